// File: rtl/stream_mux_if.sv
// Handshake bundle between N_CH valid/ready producers, the stream mux and one consumer.
// Channel i occupies in_data[i*DATA_W +: DATA_W].
interface stream_mux_if #(
  parameter int unsigned N_CH   = 8,
  parameter int unsigned DATA_W = 8
);
  localparam int unsigned SEL_W = $clog2(N_CH);

  logic                     mode;
  logic [SEL_W-1:0]         sel;
  logic [N_CH*DATA_W-1:0]   in_data;
  logic [N_CH-1:0]          in_valid;
  logic [N_CH-1:0]          in_last;
  logic [N_CH-1:0]          in_ready;
  logic [DATA_W-1:0]        out_data;
  logic                     out_valid;
  logic                     out_last;
  logic [SEL_W-1:0]         out_ch;
  logic                     out_ready;

  // Producer/consumer side.
  modport master (
    output mode, sel, in_data, in_valid, in_last, out_ready,
    input  in_ready, out_data, out_valid, out_last, out_ch
  );

  // Multiplexer side.
  modport slave (
    input  mode, sel, in_data, in_valid, in_last, out_ready,
    output in_ready, out_data, out_valid, out_last, out_ch
  );
endinterface

// File: rtl/stream_mux_rr.sv
// N-channel packet-locked stream multiplexer, manual or round-robin select,
// with a single registered output stage under full backpressure.
module stream_mux_rr #(
  parameter int unsigned N_CH   = 8,
  parameter int unsigned DATA_W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  stream_mux_if.slave  bus
);
  localparam int unsigned SEL_W    = $clog2(N_CH);
  localparam int unsigned SEL_SPAN = 1 << SEL_W;

  typedef enum logic {IDLE, BUSY} state_e;

  state_e              state_q, state_d;
  logic [SEL_W-1:0]    g_q, g_d;
  logic [SEL_W-1:0]    ptr_q, ptr_d;
  logic [DATA_W-1:0]   out_data_q, out_data_d;
  logic                out_last_q, out_last_d;
  logic [SEL_W-1:0]    out_ch_q, out_ch_d;
  logic                out_valid_q, out_valid_d;

  logic [SEL_SPAN-1:0] valid_ext;
  logic [SEL_SPAN-1:0] last_ext;
  logic [SEL_SPAN-1:0] rdy_ext;
  logic [DATA_W-1:0]   ch_data [SEL_SPAN];
  logic                space_c;
  logic                accept_c;
  logic                rr_found_c;
  logic [SEL_W-1:0]    rr_idx_c;

  // Pad per-channel vectors to the full select range so out-of-range selects read as idle.
  assign valid_ext = SEL_SPAN'(bus.in_valid);
  assign last_ext  = SEL_SPAN'(bus.in_last);

  for (genvar i = 0; i < SEL_SPAN; i++) begin : g_slice
    if (i < N_CH) begin : g_real
      assign ch_data[i] = bus.in_data[i*DATA_W +: DATA_W];
    end else begin : g_pad
      assign ch_data[i] = '0;
    end
  end

  function automatic logic [SEL_W-1:0] rr_pos(input logic [SEL_W-1:0] base, input int k);
    int unsigned s;
    s = 32'(base) + 32'(k);
    if (s >= N_CH) s = s - N_CH;
    return SEL_W'(s);
  endfunction

  // First valid channel at or after ptr, wrapping; descending scan lets the nearest win.
  always_comb begin
    rr_found_c = 1'b0;
    rr_idx_c   = '0;
    for (int k = int'(N_CH) - 1; k >= 0; k--) begin
      if (valid_ext[rr_pos(ptr_q, k)]) begin
        rr_found_c = 1'b1;
        rr_idx_c   = rr_pos(ptr_q, k);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      g_q         <= '0;
      ptr_q       <= '0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      out_ch_q    <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      g_q         <= g_d;
      ptr_q       <= ptr_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
      out_ch_q    <= out_ch_d;
      out_valid_q <= out_valid_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    g_d         = g_q;
    ptr_d       = ptr_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    out_ch_d    = out_ch_q;
    out_valid_d = out_valid_q;
    rdy_ext     = '0;
    accept_c    = 1'b0;
    space_c     = !out_valid_q || bus.out_ready;

    case (state_q)
      IDLE: begin
        if (!bus.mode) begin
          if (valid_ext[bus.sel]) begin
            g_d     = bus.sel;
            state_d = BUSY;
          end
        end else if (rr_found_c) begin
          g_d     = rr_idx_c;
          state_d = BUSY;
        end
      end
      BUSY: begin
        // Grant stays locked until the last beat, even if the source stalls.
        rdy_ext[g_q] = space_c;
        accept_c     = valid_ext[g_q] && space_c;
        if (accept_c && last_ext[g_q]) begin
          state_d = IDLE;
          ptr_d   = (g_q == SEL_W'(N_CH - 1)) ? '0 : g_q + SEL_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    if (accept_c) begin
      out_data_d  = ch_data[g_q];
      out_last_d  = last_ext[g_q];
      out_ch_d    = g_q;
      out_valid_d = 1'b1;
    end else if (bus.out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  assign bus.in_ready  = N_CH'(rdy_ext);
  assign bus.out_data  = out_data_q;
  assign bus.out_last  = out_last_q;
  assign bus.out_ch    = out_ch_q;
  assign bus.out_valid = out_valid_q;

endmodule

// File: tb/tb_stream_mux_rr.sv
// Directed bench for stream_mux_rr: per-channel source queues feed the DUT,
// a scoreboard of expected {ch,last,data} beats is popped on each output transfer.
module tb_stream_mux_rr;
  localparam int unsigned N  = 8;
  localparam int unsigned DW = 8;

  logic clk;
  logic rst_n;
  int   checks   = 0;
  int   failures = 0;
  logic sb_en    = 1'b0;

  stream_mux_if #(.N_CH(N), .DATA_W(DW)) bus ();
  stream_mux_if #(.N_CH(5), .DATA_W(DW)) bus5 ();

  stream_mux_rr #(.N_CH(N), .DATA_W(DW)) u_dut  (.clk(clk), .rst_n(rst_n), .bus(bus));
  stream_mux_rr #(.N_CH(5), .DATA_W(DW)) u_dut5 (.clk(clk), .rst_n(rst_n), .bus(bus5));

  logic [8:0]  src_q [N][$];
  logic [11:0] sb [$];
  logic [N-1:0] fire;
  logic [11:0]  exp_beat;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      $error("check %s", tag);
    end
  endtask

  task automatic src_push(input int ch, input logic [7:0] d, input logic last);
    src_q[ch].push_back({last, d});
  endtask

  task automatic exp_push(input int ch, input logic [7:0] d, input logic last);
    sb.push_back({3'(ch), last, d});
  endtask

  task automatic wait_drain(input string tag);
    int n;
    n = 0;
    while ((sb.size() != 0 || bus.out_valid) && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_drain"}, 64'(sb.size() == 0 && !bus.out_valid), 64'(1));
    repeat (2) @(negedge clk);
  endtask

  // Source driver: pops a beat after each handshake, presents queue heads after the edge.
  initial begin
    logic [8:0] head;
    bus.in_valid = '0;
    bus.in_last  = '0;
    bus.in_data  = '0;
    forever begin
      @(negedge clk);
      fire = bus.in_valid & bus.in_ready;
      @(posedge clk);
      #1;
      for (int i = 0; i < int'(N); i++) begin
        if (fire[i] && src_q[i].size() != 0) void'(src_q[i].pop_front());
        if (src_q[i].size() != 0) begin
          head = src_q[i][0];
          bus.in_valid[i]          = 1'b1;
          bus.in_last[i]           = head[8];
          bus.in_data[i*DW +: DW]  = head[7:0];
        end else begin
          bus.in_valid[i]          = 1'b0;
          bus.in_last[i]           = 1'b0;
          bus.in_data[i*DW +: DW]  = '0;
        end
      end
    end
  end

  // Scoreboard monitor: a beat transfers at the next edge when valid and ready are both high.
  always @(negedge clk) begin
    if (sb_en && rst_n && bus.out_valid && bus.out_ready) begin
      if (sb.size() == 0) begin
        chk("unexpected_beat", {52'(0), bus.out_ch, bus.out_last, bus.out_data}, 64'hFFF);
      end else begin
        exp_beat = sb.pop_front();
        chk("beat", {52'(0), bus.out_ch, bus.out_last, bus.out_data}, 64'(exp_beat));
      end
    end
  end

  initial begin
    int          lat, bub, beats, n;
    logic [N-1:0] other;
    logic         seen;
    logic [7:0]   d;

    rst_n          = 1'b0;
    bus.mode       = 1'b0;
    bus.sel        = '0;
    bus.out_ready  = 1'b1;
    bus5.mode      = 1'b0;
    bus5.sel       = 3'd5;
    bus5.in_valid  = 5'h1F;
    bus5.in_last   = 5'h1F;
    bus5.in_data   = {8'hC4, 8'hC3, 8'hC2, 8'hC1, 8'hC0};
    bus5.out_ready = 1'b1;

    repeat (3) @(negedge clk);
    chk("rst_out",  64'({bus.out_valid, bus.out_last, bus.out_ch, bus.out_data}), 64'(0));
    chk("rst_rdy",  64'(bus.in_ready), 64'(0));
    chk("rst_out5", 64'({bus5.out_valid, bus5.in_ready}), 64'(0));
    @(posedge clk); #1 rst_n = 1'b1;

    // Complete one packet on ch0 (ptr -> 1), then reset in the middle of a ch1 packet.
    bus.mode = 1'b1;
    src_push(0, 8'h11, 1'b1);
    n = 0;
    do begin @(negedge clk); n++; end while (!bus.out_valid && n < 20);
    chk("pre_rst_ch0", 64'(bus.out_valid), 64'(1));
    for (int b = 0; b < 4; b++) src_push(1, 8'h21 + 8'(b), 1'b0);
    n = 0;
    do begin @(negedge clk); n++; end while (!bus.in_ready[1] && n < 20);
    chk("pre_rst_grant1", 64'(bus.in_ready[1]), 64'(1));
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("async_rst_out", 64'({bus.out_valid, bus.out_last, bus.out_ch, bus.out_data}), 64'(0));
    for (int i = 0; i < int'(N); i++) src_q[i].delete();
    repeat (2) @(negedge clk);
    @(posedge clk); #1 rst_n = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      chk("idle_out", 64'({bus.out_valid, bus.out_last, bus.out_ch, bus.out_data}), 64'(0));
      chk("idle_rdy", 64'(bus.in_ready), 64'(0));
    end

    // Arbitration restarts at ch0 after reset: ch0 before ch5.
    sb_en = 1'b1;
    src_push(5, 8'h5F, 1'b1);
    src_push(0, 8'h0F, 1'b1);
    exp_push(0, 8'h0F, 1'b1);
    exp_push(5, 8'h5F, 1'b1);
    wait_drain("restart");

    // Manual select sweep with single-beat packets.
    bus.mode = 1'b0;
    for (int i = 0; i < int'(N); i++) begin
      bus.sel = 3'(i);
      d = 8'h01;
      d = d << i;
      src_push(i, d, 1'b1);
      exp_push(i, d, 1'b1);
      n = 0;
      do begin @(negedge clk); n++; end while (!bus.in_valid[i] && n < 10);
      lat = 0; other = '0; seen = 1'b0;
      for (int c = 0; c < 10; c++) begin
        @(negedge clk);
        lat++;
        other = other | (bus.in_ready & ~(N'(1) << i));
        seen  = seen | bus.in_ready[i];
        if (bus.out_valid) break;
      end
      chk("man_latency", 64'(lat), 64'(2));
      chk("man_other_rdy", 64'(other), 64'(0));
      chk("man_own_rdy", 64'(seen), 64'(1));
      wait_drain("manual");
    end

    // Round-robin fairness, 2-beat packets on every channel plus a second ch0 packet.
    bus.mode = 1'b1;
    for (int i = 0; i < int'(N); i++) begin
      src_push(i, 8'hA0 + 8'(i), 1'b0);
      src_push(i, 8'hB0 + 8'(i), 1'b1);
    end
    src_push(0, 8'hA0, 1'b0);
    src_push(0, 8'hB0, 1'b1);
    for (int i = 0; i < int'(N); i++) begin
      exp_push(i, 8'hA0 + 8'(i), 1'b0);
      exp_push(i, 8'hB0 + 8'(i), 1'b1);
    end
    exp_push(0, 8'hA0, 1'b0);
    exp_push(0, 8'hB0, 1'b1);
    beats = 0; bub = 0;
    for (int c = 0; c < 100 && beats < 18; c++) begin
      @(negedge clk);
      if (bus.out_valid) beats++;
      else if (beats > 0) bub++;
    end
    chk("rr_beats", 64'(beats), 64'(18));
    chk("rr_bubbles", 64'(bub), 64'(8));
    wait_drain("rr");

    // Wrap and skip: ch5 leaves ptr at 6; ch7 must win over ch2.
    src_push(5, 8'h55, 1'b1);
    exp_push(5, 8'h55, 1'b1);
    wait_drain("wrap_a");
    src_push(2, 8'h22, 1'b1);
    src_push(7, 8'h77, 1'b1);
    exp_push(7, 8'h77, 1'b1);
    exp_push(2, 8'h22, 1'b1);
    wait_drain("wrap_b");

    // Backpressure mid-packet on ch3.
    src_push(3, 8'h33, 1'b0);
    src_push(3, 8'h34, 1'b0);
    src_push(3, 8'h35, 1'b1);
    exp_push(3, 8'h33, 1'b0);
    exp_push(3, 8'h34, 1'b0);
    exp_push(3, 8'h35, 1'b1);
    n = 0;
    do begin @(negedge clk); n++; end while (!(bus.out_valid && bus.out_data == 8'h33) && n < 20);
    chk("bp_first", 64'(bus.out_data), 64'(8'h33));
    @(posedge clk); #1 bus.out_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("bp_data", 64'(bus.out_data), 64'(8'h34));
      chk("bp_valid", 64'(bus.out_valid), 64'(1));
      chk("bp_rdy3", 64'(bus.in_ready[3]), 64'(0));
    end
    @(posedge clk); #1 bus.out_ready = 1'b1;
    wait_drain("bp");

    // Random backpressure across three 3-beat packets; ptr is 4 so order is 4,6,1.
    for (int b = 0; b < 3; b++) begin
      src_push(1, 8'h10 + 8'(b), b == 2);
      src_push(4, 8'h40 + 8'(b), b == 2);
      src_push(6, 8'h60 + 8'(b), b == 2);
    end
    for (int b = 0; b < 3; b++) exp_push(4, 8'h40 + 8'(b), b == 2);
    for (int b = 0; b < 3; b++) exp_push(6, 8'h60 + 8'(b), b == 2);
    for (int b = 0; b < 3; b++) exp_push(1, 8'h10 + 8'(b), b == 2);
    for (int c = 0; c < 300 && sb.size() != 0; c++) begin
      @(posedge clk); #1 bus.out_ready = 1'($urandom_range(0, 1));
    end
    @(posedge clk); #1 bus.out_ready = 1'b1;
    wait_drain("rand_bp");

    // Packet lock: sel changes mid-packet take effect only at the next arbitration.
    bus.mode = 1'b0;
    bus.sel  = 3'd2;
    src_push(2, 8'h2A, 1'b0);
    src_push(2, 8'h2B, 1'b0);
    src_push(2, 8'h2C, 1'b1);
    src_push(5, 8'h5A, 1'b1);
    exp_push(2, 8'h2A, 1'b0);
    exp_push(2, 8'h2B, 1'b0);
    exp_push(2, 8'h2C, 1'b1);
    exp_push(5, 8'h5A, 1'b1);
    n = 0;
    do begin @(negedge clk); n++; end while (!bus.out_valid && n < 20);
    chk("lock_start_ch", 64'(bus.out_ch), 64'(2));
    bus.sel = 3'd5;
    wait_drain("lock");

    // Five-channel build: select 5 is out of range and must never grant.
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("oor_sel", 64'({bus5.out_valid, bus5.in_ready}), 64'(0));
    end
    bus5.sel = 3'd4;
    repeat (4) @(negedge clk);
    chk("n5_sel4", 64'({bus5.out_valid, bus5.out_ch, bus5.out_data}), 64'({1'b1, 3'd4, 8'hC4}));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
